// File: rtl/alu_issue.sv
// Issue stage between ID and EX: decodes one RV32I instruction per handshake into ALU controls and operands.
// Two-entry skid buffer (output slot + skid). Optional result bypass enabled by ALU_ISSUE_FWD_EN.
module alu_issue #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_rdata,
    input  logic [XLEN-1:0] rs2_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      ctl,
    output logic [3:0]      msg,
    output logic [XLEN-1:0] rs1_v,
    output logic [XLEN-1:0] rs2_v,
    output logic [4:0]      rd,
`ifdef ALU_ISSUE_FWD_EN
    input  logic            fwd_we,
    input  logic [4:0]      fwd_rd,
    input  logic [XLEN-1:0] fwd_v,
`endif
    output logic            unsup
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
`ifdef ALU_ISSUE_FWD_EN
        logic            use1;
        logic            use2;
        logic [4:0]      rs1_idx;
        logic [4:0]      rs2_idx;
`endif
        logic            unsup;
        logic [4:0]      ctl;
        logic [3:0]      msg;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
    } entry_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    function automatic entry_t decode(
        input logic [31:0]     ins,
        input logic [XLEN-1:0] pcv,
        input logic [XLEN-1:0] r1,
        input logic [XLEN-1:0] r2
    );
        entry_t          e;
        logic [XLEN-1:0] imm_i;
        logic [XLEN-1:0] imm_s;
        logic [XLEN-1:0] imm_u;
        e     = '0;
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_u = {ins[31:12], 12'h000};
        case (ins[6:0])
            OPC_OP: begin
                e.ctl = 5'b10001;
                e.msg = {ins[30], ins[14:12]};
                e.a   = r1;
                e.b   = r2;
            end
            OPC_OPIMM: begin
                // Only shifts (f3=101) use instr[30] as an op bit; elsewhere it is immediate.
                e.ctl = 5'b10001;
                e.msg = {(ins[14:12] == 3'b101) ? ins[30] : 1'b0, ins[14:12]};
                e.a   = r1;
                e.b   = imm_i;
            end
            OPC_LOAD: begin
                e.ctl = 5'b10010;
                e.a   = r1;
                e.b   = imm_i;
            end
            OPC_STORE: begin
                e.ctl = 5'b00100;
                e.a   = r1;
                e.b   = imm_s;
            end
            OPC_LUI: begin
                e.ctl = 5'b10001;
                e.b   = imm_u;
            end
            OPC_AUIPC: begin
                e.ctl = 5'b10001;
                e.a   = pcv;
                e.b   = imm_u;
            end
            OPC_JALR: begin
                e.ctl = 5'b11000;
                e.a   = r1;
                e.b   = imm_i;
            end
            default: begin
                e.unsup = 1'b1;
            end
        endcase
        e.rd = e.ctl[4] ? ins[11:7] : 5'd0;
`ifdef ALU_ISSUE_FWD_EN
        e.use1    = !e.unsup && (ins[6:0] != OPC_LUI) && (ins[6:0] != OPC_AUIPC);
        e.use2    = (ins[6:0] == OPC_OP);
        e.rs1_idx = ins[19:15];
        e.rs2_idx = ins[24:20];
`endif
        return e;
    endfunction

    state_t          state_q, state_d;
    entry_t          slot_q, slot_d;
    entry_t          skid_q, skid_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            in_fire_s;
    logic            out_fire_s;
    logic [XLEN-1:0] rs1_eff_s;
    logic [XLEN-1:0] rs2_eff_s;
    entry_t          dec_s;
    entry_t          skid_cur_s;
    logic            unused_reset_pc_s;

    assign unused_reset_pc_s = ^RESET_PC;

    // Operand selection at decode and patching of the waiting skid entry.
    always_comb begin
        rs1_eff_s  = rs1_rdata;
        rs2_eff_s  = rs2_rdata;
        skid_cur_s = skid_q;
`ifdef ALU_ISSUE_FWD_EN
        if (fwd_we && (fwd_rd != 5'd0) && (fwd_rd == instr[19:15])) begin
            rs1_eff_s = fwd_v;
        end else begin
            rs1_eff_s = rs1_rdata;
        end
        if (fwd_we && (fwd_rd != 5'd0) && (fwd_rd == instr[24:20])) begin
            rs2_eff_s = fwd_v;
        end else begin
            rs2_eff_s = rs2_rdata;
        end
        if ((state_q == ST_FULL) && fwd_we && (fwd_rd != 5'd0) && skid_q.use1 &&
            (fwd_rd == skid_q.rs1_idx)) begin
            skid_cur_s.a = fwd_v;
        end else begin
            skid_cur_s.a = skid_q.a;
        end
        if ((state_q == ST_FULL) && fwd_we && (fwd_rd != 5'd0) && skid_q.use2 &&
            (fwd_rd == skid_q.rs2_idx)) begin
            skid_cur_s.b = fwd_v;
        end else begin
            skid_cur_s.b = skid_q.b;
        end
`endif
    end

    assign dec_s = decode(instr, pc, rs1_eff_s, rs2_eff_s);

    // Occupancy FSM: output slot always holds the oldest entry, skid the younger one.
    always_comb begin
        in_fire_s  = in_valid & in_ready_q;
        out_fire_s = out_valid_q & out_ready;
        state_d    = state_q;
        slot_d     = slot_q;
        skid_d     = skid_cur_s;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        slot_d  = dec_s;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        slot_d = dec_s;
                    end else if (in_fire_s) begin
                        skid_d  = dec_s;
                        state_d = ST_FULL;
                    end else if (out_fire_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        slot_d  = skid_cur_s;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    // State, payload and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            slot_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign ctl       = slot_q.ctl;
    assign msg       = slot_q.msg;
    assign rs1_v     = slot_q.a;
    assign rs2_v     = slot_q.b;
    assign rd        = slot_q.rd;
    assign unsup     = slot_q.unsup;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed decode/flow steps plus random traffic against a queue model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'h0;
    logic [31:0] pc = 32'h0;
    logic [31:0] rs1_rdata = 32'h0;
    logic [31:0] rs2_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  ctl;
    logic [3:0]  msg;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [4:0]  rd;
    logic        unsup;
`ifdef ALU_ISSUE_FWD_EN
    logic        fwd_we = 1'b0;
    logic [4:0]  fwd_rd = 5'd0;
    logic [31:0] fwd_v = 32'h0;
`endif

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctl(ctl), .msg(msg), .rs1_v(rs1_v), .rs2_v(rs2_v), .rd(rd),
`ifdef ALU_ISSUE_FWD_EN
        .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_v(fwd_v),
`endif
        .unsup(unsup)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        unsup;
        logic [4:0]  ctl;
        logic [3:0]  msg;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } exp_t;

    exp_t model_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_out = 0;

    // Reference decode from the instruction-set rules, using plain arithmetic for immediates.
    function automatic exp_t ref_dec(logic [31:0] ins, logic [31:0] pcv, logic [31:0] r1, logic [31:0] r2);
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_u;
        e  = '0;
        op = ins[6:0];
        f3 = ins[14:12];
        imm_i = 32'(ins[31:20]);
        if (ins[31]) imm_i = imm_i - 32'd4096;
        imm_s = 32'({ins[31:25], ins[11:7]});
        if (ins[31]) imm_s = imm_s - 32'd4096;
        imm_u = ins & 32'hFFFF_F000;
        if (op == 7'b0110011) begin
            e.ctl = 5'b10001; e.msg = {ins[30], f3}; e.a = r1; e.b = r2;
        end else if (op == 7'b0010011) begin
            e.ctl = 5'b10001; e.msg = {(f3 == 3'd5) && ins[30], f3}; e.a = r1; e.b = imm_i;
        end else if (op == 7'b0000011) begin
            e.ctl = 5'b10010; e.a = r1; e.b = imm_i;
        end else if (op == 7'b0100011) begin
            e.ctl = 5'b00100; e.a = r1; e.b = imm_s;
        end else if (op == 7'b0110111) begin
            e.ctl = 5'b10001; e.b = imm_u;
        end else if (op == 7'b0010111) begin
            e.ctl = 5'b10001; e.a = pcv; e.b = imm_u;
        end else if (op == 7'b1100111) begin
            e.ctl = 5'b11000; e.a = r1; e.b = imm_i;
        end else begin
            e.unsup = 1'b1;
        end
        if (e.ctl[4]) e.rd = ins[11:7];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check_all();
        exp_t h;
        chk("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(model_q.size() < 2));
        if (model_q.size() > 0) begin
            h = model_q[0];
            chk("ctl", 32'(ctl), 32'(h.ctl));
            chk("msg", 32'(msg), 32'(h.msg));
            chk("rs1_v", rs1_v, h.a);
            chk("rs2_v", rs2_v, h.b);
            chk("rd", 32'(rd), 32'(h.rd));
            chk("unsup", 32'(unsup), 32'(h.unsup));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, 32'(ctl), 32'd0);
        chk({tag, "_msg"}, 32'(msg), 32'd0);
        chk({tag, "_rs1"}, rs1_v, 32'd0);
        chk({tag, "_rs2"}, rs2_v, 32'd0);
        chk({tag, "_rd"}, 32'(rd), 32'd0);
        chk({tag, "_unsup"}, 32'(unsup), 32'd0);
    endtask

    // One clock: drive at negedge, update the model at the edge, check at the next negedge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] r1, input logic [31:0] r2, input logic ordy, input logic fl);
        logic ie;
        logic oe;
        in_valid = v; instr = ins; pc = p; rs1_rdata = r1; rs2_rdata = r2;
        out_ready = ordy; flush = fl;
        ie = v && (model_q.size() < 2);
        oe = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (oe) begin
                void'(model_q.pop_front());
                n_out++;
            end
            if (ie) model_q.push_back(ref_dec(ins, p, r1, r2));
        end
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        logic [31:0] w;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111,
                7'b0010111, 7'b1100111, 7'b1101111, 7'b1100011, 7'b1110011};
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 9)];
        return w;
    endfunction

    localparam logic [31:0] I_ADD  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] I_SRAI = {7'b0100000, 5'd3, 5'd1, 3'b101, 5'd4, 7'b0010011};
    localparam logic [31:0] I_SW   = {7'b1111111, 5'd2, 5'd1, 3'b010, 5'b11100, 7'b0100011};

    initial begin : main
        logic [31:0] bp_ins [4];
        logic [31:0] cur_ins, cur_pc, cur_r1, cur_r2;
        logic        cur_v;
        int          idx;
        int          budget;
        int          out_base;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all();
        check_zero("reset");

        // add x3,x1,x2
        step(1'b1, I_ADD, 32'h100, 32'd5, 32'd7, 1'b1, 1'b0);
        chk("add_ctl", 32'(ctl), 32'b10001);
        chk("add_msg", 32'(msg), 32'b0000);
        chk("add_a", rs1_v, 32'd5);
        chk("add_b", rs2_v, 32'd7);
        chk("add_rd", 32'(rd), 32'd3);
        // srai x4,x1,3 (accepted while add leaves: throughput 1/cycle)
        step(1'b1, I_SRAI, 32'h104, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);
        chk("srai_msg", 32'(msg), 32'b1101);
        chk("srai_b", rs2_v, 32'h0000_0403);
        // sw x2,-4(x1)
        step(1'b1, I_SW, 32'h108, 32'h40, 32'h99, 1'b1, 1'b0);
        chk("sw_ctl", 32'(ctl), 32'b00100);
        chk("sw_b", rs2_v, 32'hFFFF_FFFC);
        chk("sw_rd", 32'(rd), 32'd0);
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Back-pressure: four instructions with EX stalled, then drained.
        for (int i = 0; i < 4; i++) bp_ins[i] = {12'(i + 1), 5'd1, 3'b000, 5'(i + 5), 7'b0010011};
        out_base = n_out;
        idx = 0;
        budget = 0;
        while (idx < 4 && budget < 40) begin
            cur_v = in_ready;
            step(1'b1, bp_ins[idx], 32'h200, 32'(idx * 3), 32'h0, (idx >= 2) && !in_ready, 1'b0);
            if (cur_v) idx++;
            if (idx == 2 && budget < 2) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            budget++;
        end
        chk("bp_all_accepted", 32'(idx), 32'd4);
        budget = 0;
        while (out_valid && budget < 20) begin
            step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
            budget++;
        end
        chk("bp_out_count", 32'(n_out - out_base), 32'd4);

        // Flush while full with a new instruction offered.
        step(1'b1, I_ADD, 32'h300, 32'd1, 32'd2, 1'b0, 1'b0);
        step(1'b1, I_SRAI, 32'h304, 32'd3, 32'd4, 1'b0, 1'b0);
        chk("pre_flush_full", 32'(in_ready), 32'd0);
        step(1'b1, I_SW, 32'h308, 32'd5, 32'd6, 1'b0, 1'b1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream.
        step(1'b1, I_ADD, 32'h400, 32'd11, 32'd12, 1'b0, 1'b0);
        step(1'b1, I_SW, 32'h404, 32'd13, 32'd14, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        check_zero("async_rst");
        model_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_zero("post_rst");

        // Random traffic; an offered instruction is held until accepted or flushed.
        cur_v = 1'b0;
        cur_ins = 32'h0; cur_pc = 32'h0; cur_r1 = 32'h0; cur_r2 = 32'h0;
        for (int c = 0; c < 500; c++) begin
            logic acc;
            logic fl;
            if (!cur_v) begin
                cur_v   = ($urandom % 4) != 0;
                cur_ins = rand_instr();
                cur_pc  = $urandom & 32'hFFFF_FFFC;
                cur_r1  = $urandom;
                cur_r2  = $urandom;
            end
            fl  = ($urandom % 25) == 0;
            acc = cur_v && in_ready;
            step(cur_v, cur_ins, cur_pc, cur_r1, cur_r2, ($urandom % 3) != 0, fl);
            if (acc || fl) cur_v = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
